// File: rtl/mem_fabric_pkg.sv
// Shared types and default address map for the mem_fabric request router.
package mem_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_N_TGT   = 4;
    localparam int DEF_TIMEOUT = 16;

    // Index 0 occupies the least-significant ADDR_W bits.
    localparam logic [DEF_N_TGT*DEF_ADDR_W-1:0] DEF_TGT_BASE = {
        64'h0000_0000_0000_0000,
        64'h0000_0000_0000_0000,
        64'hFFFF_FFFF_0000_0000,
        64'hFFFF_FFFF_FFFF_0000
    };

    localparam logic [DEF_N_TGT*DEF_ADDR_W-1:0] DEF_TGT_MASK = {
        64'h0000_0000_0000_0000,
        64'hFFFF_FFFF_FF00_0000,
        64'hFFFF_FFFF_0000_0000,
        64'hFFFF_FFFF_FFFF_0000
    };

endpackage

// File: rtl/mem_fabric_decode.sv
// Masked address compare with lowest-index priority; yields hit, one-hot select
// and the target-relative offset.
module fabric_decode #(
    parameter int                      ADDR_W   = 64,
    parameter int                      N_TGT    = 4,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = '0,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [N_TGT-1:0]  sel_o,
    output logic [ADDR_W-1:0] offset_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        hit_o    = 1'b0;
        sel_o    = '0;
        offset_o = '0;
        // Walk from the top index down so the lowest matching index is written last.
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((addr_i & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_o    = 1'b1;
                sel_o    = '0;
                sel_o[i] = 1'b1;
                offset_o = addr_i & ~TGT_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mem_fabric.sv
// Single-outstanding request router: decodes an initiator request onto one of
// N_TGT target channels, waits for ready with a timeout, and returns one response.
module mem_fabric
    import mem_fabric_pkg::*;
#(
    parameter int                      ADDR_W   = 64,
    parameter int                      DATA_W   = 64,
    parameter int                      N_TGT    = 4,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK,
    parameter int                      TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_valid,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [3:0]                req_size,
    input  logic                      req_rw,
    output logic                      req_ready,

    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,

    output logic [N_TGT-1:0]          tgt_valid,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_wdata,
    output logic [3:0]                tgt_size,
    output logic                      tgt_rw,
    input  logic [N_TGT-1:0]          tgt_ready,
    input  logic [N_TGT*DATA_W-1:0]   tgt_rdata,

    output logic [15:0]               err_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          size_q, size_d;
    logic                rw_q, rw_d;
    logic [N_TGT-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic                dec_hit;
    logic [N_TGT-1:0]    dec_sel;
    logic [ADDR_W-1:0]   dec_offset;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    fabric_decode #(
        .ADDR_W   (ADDR_W),
        .N_TGT    (N_TGT),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .addr_i   (req_addr),
        .hit_o    (dec_hit),
        .sel_o    (dec_sel),
        .offset_o (dec_offset)
    );

    // Only the latched channel's ready/rdata are ever looked at.
    assign sel_ready = |(tgt_ready & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (sel_q[i]) sel_rdata = tgt_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        rw_d      = rw_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = dec_offset;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    rw_d    = req_rw;
                    sel_d   = dec_sel;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = ~dec_hit;
                    state_d = dec_hit ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                // Ready on the last allowed cycle still wins over the timeout.
                if (sel_ready) begin
                    rdata_d = rw_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            rw_q      <= 1'b0;
            sel_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            rw_q      <= rw_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign tgt_valid  = (state_q == ISSUE) ? sel_q : '0;
    assign tgt_addr   = addr_q;
    assign tgt_wdata  = wdata_q;
    assign tgt_size   = size_q;
    assign tgt_rw     = rw_q;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) & err_q;
    assign resp_rdata = rdata_q;
    assign err_count  = err_cnt_q;

endmodule

// File: doc/mem_fabric.md
MEM_FABRIC -- requirements
Module: mem_fabric

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data word width.
REQ-003 SHALL have parameter N_TGT, default 4, meaning number of target channels (1..8).
REQ-004 SHALL have parameter TGT_BASE, default {FFFF_FFFF_FFFF_0000, FFFF_FFFF_0000_0000, 0, 0} (index 0 first), meaning per-target base address, N_TGT x ADDR_W packed.
REQ-005 SHALL have parameter TGT_MASK, default {FFFF_FFFF_FFFF_0000, FFFF_FFFF_0000_0000, FFFF_FFFF_FF00_0000, 0}, meaning per-target compare mask, N_TGT x ADDR_W packed.
REQ-006 SHALL have parameter TIMEOUT, default 16, meaning maximum ISSUE cycles before bus error.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports req_valid in 1, req_addr in ADDR_W, req_wdata in DATA_W, req_size in 4 (bytes), req_rw in 1 (1 = write), and req_ready out 1.
REQ-010 SHALL have ports resp_valid out 1, resp_rdata out DATA_W, and resp_err out 1.
REQ-011 SHALL have ports tgt_valid out N_TGT, tgt_addr out ADDR_W (offset = addr & ~mask), tgt_wdata out DATA_W, tgt_size out 4, and tgt_rw out 1.
REQ-012 SHALL have ports tgt_ready in N_TGT and tgt_rdata in N_TGT x DATA_W.
REQ-013 SHALL have port err_count, out, 16, a saturating count of error responses.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, RESP, with req_ready = (state == IDLE).
REQ-015 SHALL, in IDLE with req_valid high, register address, data, size and rw, decode the target, and move to ISSUE if a target matches, else to RESP with the error flag set.
REQ-016 SHALL decode a target i as a match when (req_addr & TGT_MASK[i]) == TGT_BASE[i], with the lowest matching index winning on overlap.
REQ-017 SHALL hold tgt_valid one-hot on the selected channel throughout ISSUE, with all other bits and all non-ISSUE states giving zero.
REQ-018 SHALL, in ISSUE with tgt_ready[sel] high, capture tgt_rdata[sel] (zero for writes) and move to RESP with no error.
REQ-019 SHALL count ISSUE cycles, and on reaching TIMEOUT without ready, drop tgt_valid and move to RESP with the error flag set.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP, with resp_err equal to the flag, resp_rdata equal to the captured data (zero on error), and return to IDLE.
REQ-021 SHALL give a best-case latency from request acceptance to resp_valid of 2 cycles (accept, ISSUE with ready, RESP).
REQ-022 SHALL increment err_count on each error response and saturate it at FFFF.
REQ-023 SHALL ignore tgt_ready on unselected channels and outside ISSUE.
REQ-024 SHALL apply no backpressure on the response; the initiator must accept resp_valid.

Reset
REQ-025 SHALL, on reset asserted, immediately (asynchronously) force state to IDLE, tgt_valid to 0, resp_valid to 0, resp_err to 0, resp_rdata to 0, err_count to 0, and the timeout counter to 0.
REQ-026 SHALL, on reset mid-transaction, drop the transaction with no response, and SHALL accept a new request on the first clock edge after deassertion.

Structure
REQ-027 SHALL define in package mem_fabric_pkg the state enum, the default TGT_BASE and TGT_MASK constants, and the TIMEOUT default.
REQ-028 SHALL place the combinational masked compare and priority one-hot select in sub-module fabric_decode (outputs: hit, sel one-hot, offset address).

Verification
REQ-029 SHALL verify: a read at FFFF_FFFF_FFFF_0010 with tgt_ready[0] high in the first ISSUE cycle and tgt_rdata[0] = 1122_3344_5566_7788 -> tgt_valid = 0001, tgt_addr = 10, and resp_valid 2 cycles after acceptance with that data and err = 0.
REQ-030 SHALL verify: a write to 0000_0000_0000_0100, size 8, with target 2 ready after 3 wait cycles -> tgt_valid = 0100 for 4 cycles, then resp_valid with err = 0 and rdata = 0.
REQ-031 SHALL verify: a request to 0000_0001_0000_0000 with TGT_MASK[3] = 0 -> the catch-all target 3 is selected; with N_TGT = 3 it instead gives an immediate error, resp_err = 1, and err_count = 1.
REQ-032 SHALL verify: a target that never asserts ready -> tgt_valid drops after 16 cycles, resp_err = 1 pulses once, and err_count increments.
REQ-033 SHALL verify: reset asserted during ISSUE -> tgt_valid = 0 the same cycle, no resp_valid, req_ready = 1 after release, and the next request completes normally.
REQ-034 SHALL verify: 65540 forced errors -> err_count holds FFFF.
